iterative_divider_32bit: RTL and testbench

ITERATIVE_DIVIDER_32BIT -- requirements
Module: iterative_divider_32bit

---
 rtl/iterative_divider_32bit_pkg.sv | 42 ++++
 rtl/leading_zero_counter_32bit.sv | 27 ++
 rtl/iterative_divider_32bit.sv | 187 ++++++++++++++++++
 tb/tb_iterative_divider_32bit.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iterative_divider_32bit_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : iterative_divider_32bit_pkg
// Description : Shared types and constants for the RV32M iterative divider.
// Revision    : 1.0 - initial release
// ============================================================================
package iterative_divider_32bit_pkg;

  localparam int XLEN = 32;
  localparam int CNT_W = 6;

  localparam logic [XLEN-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN    = 32'h8000_0000;

  // Operation encoding matches the funct3[1:0] ordering of RV32M division ops
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_NORM  = 2'b01,
    ST_ITER  = 2'b10,
    ST_FIXUP = 2'b11
  } state_e;

  // Signed operations are the ones with op[0] clear (DIV, REM)
  function automatic logic op_is_signed(input op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Remainder operations are the ones with op[1] set (REM, REMU)
  function automatic logic op_is_rem(input op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/leading_zero_counter_32bit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : leading_zero_counter_32bit
// Description : Counts leading zeros of a 32-bit word (0..32) and flags zero.
// Revision    : 1.0 - initial release
// ============================================================================
module leading_zero_counter_32bit
  import iterative_divider_32bit_pkg::*;
(
  input  logic [XLEN-1:0]  value,
  output logic [CNT_W-1:0] nlz,
  output logic             all_zero
);

  // Scan upward so the highest set bit is the last one to write nlz
  always_comb begin
    nlz = CNT_W'(XLEN);
    for (int i = 0; i < XLEN; i++) begin
      if (value[i]) nlz = CNT_W'(XLEN - 1 - i);
    end
  end

  assign all_zero = (value == '0);

endmodule
`default_nettype wire

// File: rtl/iterative_divider_32bit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : iterative_divider_32bit
// Description : RV32M DIV/DIVU/REM/REMU, one restoring step per cycle, with
//               optional early-out on dividend leading zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module iterative_divider_32bit
  import iterative_divider_32bit_pkg::*;
#(
  parameter int EARLY_OUT = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_flush,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_busy,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);

  state_e state, state_next;

  op_e             op;
  logic            div_zero;
  logic            ovf;
  logic            sign_a;
  logic            sign_b;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0] result;
  logic            valid;

  // Operand conditioning in IDLE
  op_e             in_op;
  logic            in_signed;
  logic [XLEN-1:0] in_abs_a;
  logic [XLEN-1:0] in_abs_b;
  logic            accept;

  // Normalisation
  logic [CNT_W-1:0] nlz;
  logic             a_zero;
  logic [CNT_W-1:0] norm_k;
  logic [XLEN-1:0]  norm_quo;

  // Restoring step
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   diff;
  logic            take;

  // Sign / special-case fixup
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic [XLEN-1:0] fix_result;

  leading_zero_counter_32bit u_lzc (
    .value    (dividend),
    .nlz      (nlz),
    .all_zero (a_zero)
  );

  // Decode the incoming request into magnitudes and special-case flags
  always_comb begin
    in_op     = op_e'(i_op);
    in_signed = op_is_signed(in_op);
    in_abs_a  = (in_signed && i_rs1[XLEN-1]) ? -i_rs1 : i_rs1;
    in_abs_b  = (in_signed && i_rs2[XLEN-1]) ? -i_rs2 : i_rs2;
    accept    = (state == ST_IDLE) && i_start && !i_flush;
  end

  // Iteration count and pre-shifted quotient; an all-zero dividend needs no steps
  always_comb begin
    if (EARLY_OUT != 0) begin
      norm_k   = a_zero ? '0 : CNT_W'(XLEN) - nlz;
      norm_quo = dividend << nlz;
    end else begin
      norm_k   = CNT_W'(XLEN);
      norm_quo = dividend;
    end
  end

  // One restoring step; the remainder stays below the divisor, so a set
  // carry-out bit after the shift always means the subtraction fits
  always_comb begin
    rem_shift = {rem, quo[XLEN-1]};
    diff      = rem_shift - {1'b0, divisor};
    take      = rem_shift[XLEN] | ~diff[XLEN];
  end

  // Final result selection with RV32M special cases and sign correction
  always_comb begin
    q_fix = quo;
    r_fix = rem;
    if (div_zero) begin
      q_fix = DIV_ZERO_Q;
      r_fix = dividend;
    end else if (ovf) begin
      q_fix = INT_MIN;
      r_fix = '0;
    end else if (sign_a ^ sign_b) begin
      q_fix = -quo;
    end
    // Remainder follows the dividend sign; for divide-by-zero this rebuilds rs1
    if (sign_a) r_fix = -r_fix;
    fix_result = op_is_rem(op) ? r_fix : q_fix;
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next-state logic; flush overrides everything, including a new start
  always_comb begin
    state_next = state;
    if (i_flush) begin
      state_next = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:  if (i_start) state_next = ST_NORM;
        ST_NORM:  state_next = (norm_k == '0 || div_zero || ovf) ? ST_FIXUP : ST_ITER;
        ST_ITER:  if (count == CNT_W'(1)) state_next = ST_FIXUP;
        ST_FIXUP: state_next = ST_IDLE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // Datapath registers: capture, normalise, iterate, publish
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op       <= OP_DIV;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      dividend <= '0;
      divisor  <= '0;
      quo      <= '0;
      rem      <= '0;
      count    <= '0;
      result   <= '0;
      valid    <= 1'b0;
    end else begin
      valid <= (state == ST_FIXUP) && !i_flush;
      if (accept) begin
        op       <= in_op;
        div_zero <= (i_rs2 == '0);
        ovf      <= in_signed && (i_rs1 == INT_MIN) && (i_rs2 == '1);
        sign_a   <= in_signed && i_rs1[XLEN-1];
        sign_b   <= in_signed && i_rs2[XLEN-1];
        dividend <= in_abs_a;
        divisor  <= in_abs_b;
      end else if (!i_flush) begin
        unique case (state)
          ST_NORM: begin
            quo   <= norm_quo;
            rem   <= '0;
            count <= norm_k;
          end
          ST_ITER: begin
            quo   <= {quo[XLEN-2:0], take};
            rem   <= take ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
            count <= count - CNT_W'(1);
          end
          ST_FIXUP: result <= fix_result;
          default: ;
        endcase
      end
    end
  end

  assign o_busy   = (state != ST_IDLE);
  assign o_valid  = valid;
  assign o_result = result;

endmodule
`default_nettype wire

// File: tb/tb_iterative_divider_32bit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_iterative_divider_32bit
// Description : Self-checking bench for the iterative divider against an
//               arithmetic reference model (result and latency).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iterative_divider_32bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        busy;
  logic        valid;
  logic [31:0] result;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  iterative_divider_32bit #(.EARLY_OUT(1)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_flush  (flush),
    .i_op     (op),
    .i_rs1    (rs1),
    .i_rs2    (rs2),
    .o_busy   (busy),
    .o_valid  (valid),
    .o_result (result)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_result(input logic [1:0] f_op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f_op)
      DIV:     if (b == 0) return 32'hFFFF_FFFF;
               else if (ovf) return 32'h8000_0000;
               else return $signed(a) / $signed(b);
      DIVU:    if (b == 0) return 32'hFFFF_FFFF; else return a / b;
      REM:     if (b == 0) return a;
               else if (ovf) return 32'h0;
               else return $signed(a) % $signed(b);
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  // Latency = significant bits of |dividend| + 3, or 3 for special cases
  function automatic int ref_latency(input logic [1:0] f_op, input logic [31:0] a,
                                     input logic [31:0] b);
    logic [31:0] v;
    int k;
    bit sgn;
    sgn = (f_op == DIV) || (f_op == REM);
    if (b == 0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 3;
    v = (sgn && a[31]) ? -a : a;
    k = 0;
    while (v != 0) begin
      k++;
      v = v >> 1;
    end
    return k + 3;
  endfunction

  // ---------------- stimulus helpers ----------------
  // Called at a negedge; returns just after the accepting edge with inputs scrambled
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 2'($urandom);
    rs1 = $urandom;
    rs2 = $urandom;
  endtask

  // Counts falling edges after the accepting edge until o_valid is seen
  task automatic wait_result(output logic [31:0] r, output int lat, output bit got);
    lat = 0; got = 1'b0; r = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (valid) begin
        got = 1'b1;
        r = result;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, valid, result} !== 34'h0) begin
      n_err++;
      $display("FAIL reset_outputs: busy=%b valid=%b result=%h, required 0/0/0", busy, valid, result);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_r;
    int          exp_lat;
  } vec_t;

  task automatic test_directed();
    vec_t v[10];
    logic [31:0] r;
    int lat;
    bit got;
    v[0] = '{DIVU, 32'd100,        32'd7,          32'd14,         10};
    v[1] = '{REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  6};
    v[2] = '{DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  6};
    v[3] = '{DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  3};
    v[4] = '{REM,  32'd5,          32'd0,          32'd5,          3};
    v[5] = '{DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  3};
    v[6] = '{REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          3};
    v[7] = '{DIVU, 32'd0,          32'd9,          32'd0,          3};
    v[8] = '{DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  35};
    v[9] = '{REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  3};
    foreach (v[i]) begin
      issue(v[i].o, v[i].a, v[i].b);
      wait_result(r, lat, got);
      n_cmp++;
      if (!got) begin
        n_err++;
        $display("FAIL directed_%0d_timeout: no o_valid within 40 cycles", i);
      end else begin
        if (r !== v[i].exp_r) begin
          n_err++;
          $display("FAIL directed_%0d_result: got %h, required %h", i, r, v[i].exp_r);
        end
        n_cmp++;
        if (lat != v[i].exp_lat) begin
          n_err++;
          $display("FAIL directed_%0d_latency: got %0d, required %0d", i, lat, v[i].exp_lat);
        end
      end
      @(negedge clk);
      n_cmp++;
      if (valid !== 1'b0) begin
        n_err++;
        $display("FAIL directed_%0d_pulse: o_valid=%b one cycle later, required 0", i, valid);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a, b, r;
    int lat;
    bit got;
    for (int i = 0; i < 150; i++) begin
      o = 2'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: ;
        1: b = $urandom_range(1, 15);
        2: b = 32'h0;
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        4: a = a >> $urandom_range(0, 31);
        default: b = b >> $urandom_range(0, 31);
      endcase
      issue(o, a, b);
      wait_result(r, lat, got);
      n_cmp++;
      if (!got) begin
        n_err++;
        $display("FAIL random_%0d_timeout: op=%0d a=%h b=%h no o_valid", i, o, a, b);
      end else begin
        if (r !== ref_result(o, a, b)) begin
          n_err++;
          $display("FAIL random_%0d_result: op=%0d a=%h b=%h got %h, required %h",
                   i, o, a, b, r, ref_result(o, a, b));
        end
        n_cmp++;
        if (lat != ref_latency(o, a, b)) begin
          n_err++;
          $display("FAIL random_%0d_latency: op=%0d a=%h b=%h got %0d, required %0d",
                   i, o, a, b, lat, ref_latency(o, a, b));
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_flush();
    logic [31:0] r;
    int lat;
    bit got;
    bit seen;
    issue(DIVU, 32'd21, 32'd4);
    wait_result(r, lat, got);
    n_cmp++;
    if (!got || r !== 32'd5) begin
      n_err++;
      $display("FAIL flush_setup: got %h (valid seen=%b), required 5", r, got);
    end
    @(negedge clk);
    // Long op; falling edges 1..5 are NORM, ITER1..ITER4
    issue(DIVU, 32'hFFFF_FFFF, 32'd3);
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_idle: busy=%b valid=%b, required 0/0", busy, valid);
    end
    // Flush together with start: the start is dropped
    op = DIVU; rs1 = 32'd77; rs2 = 32'd7; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL flush_start_drop: busy=%b, required 0", busy);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (valid) seen = 1'b1;
    end
    n_cmp++;
    if (seen || result !== 32'd5) begin
      n_err++;
      $display("FAIL flush_no_valid: valid seen=%b result=%h, required 0 and 00000005", seen, result);
    end
    issue(DIVU, 32'd9, 32'd3);
    wait_result(r, lat, got);
    n_cmp++;
    if (!got || r !== 32'd3) begin
      n_err++;
      $display("FAIL flush_after: got %h (valid seen=%b), required 3", r, got);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    int lat;
    bit got;
    bit seen;
    issue(DIVU, 32'hFFFF_FFFF, 32'd7);
    // Starts while busy must be ignored
    repeat (3) begin
      @(negedge clk);
      op = DIVU; rs1 = 32'd1; rs2 = 32'd1; start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (valid) break;
      @(negedge clk);
    end
    n_cmp++;
    if (valid !== 1'b1 || result !== 32'h2492_4924) begin
      n_err++;
      $display("FAIL b2b_first: valid=%b result=%h, required 1 and 24924924", valid, result);
    end
    // Start in the o_valid cycle
    issue(REM, 32'hFFFF_FF9C, 32'd7);
    wait_result(r, lat, got);
    n_cmp++;
    if (!got || r !== 32'hFFFF_FFFE || lat != 10) begin
      n_err++;
      $display("FAIL b2b_second: got %h lat %0d (valid seen=%b), required fffffffe lat 10", r, lat, got);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (valid) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_err++;
      $display("FAIL b2b_stray_valid: extra o_valid=1, required none");
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    int lat;
    bit got;
    issue(DIVU, 32'd1000, 32'd3);
    wait_result(r, lat, got);
    n_cmp++;
    if (!got || r !== 32'd333) begin
      n_err++;
      $display("FAIL rstmid_setup: got %h, required 0000014d", r);
    end
    @(negedge clk);
    issue(DIVU, 32'hFFFF_FFFF, 32'd5);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, valid, result} !== 34'h0) begin
      n_err++;
      $display("FAIL rstmid_outputs: busy=%b valid=%b result=%h, required 0/0/0", busy, valid, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // First edge after release accepts; a leftover op would give a different value/latency
    issue(DIVU, 32'd50, 32'd5);
    wait_result(r, lat, got);
    n_cmp++;
    if (!got || r !== 32'd10 || lat != 9) begin
      n_err++;
      $display("FAIL rstmid_after: got %h lat %0d (valid seen=%b), required 0000000a lat 9", r, lat, got);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
